// File: rtl/tm1638_req_if.sv
// tm1638_req_if: one requester's update request toward the scheduler.
// Level req held until the one-clk ack pulse.
interface tm1638_req_if;
  logic        req;
  logic [7:0]  mask;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        ack;

  modport master (
    output req, mask, value, dp,
    input  ack
  );

  modport slave (
    input  req, mask, value, dp,
    output ack
  );
endinterface

// File: rtl/tm1638_sched.sv
// tm1638_sched: shares the TM1638 driver between two requesters,
// expanding each request into per-digit writes plus a transfer holdoff.
module tm1638_sched #(
  parameter int HOLDOFF = 440
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  tm1638_req_if.slave a,
  tm1638_req_if.slave b,
  output logic        wr,
  output logic [7:0]  mask,
  output logic [7:0]  data,
  output logic        busy
);
  localparam int CW = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] HMAX = CW'(HOLDOFF);

  typedef enum logic [2:0] {
    IDLE, SCAN, WR_HI, WR_LO, HOLD
  } state_t;

  state_t        state;
  logic          ptr_b;
  logic          issued;
  logic          a_ack;
  logic          b_ack;
  logic [7:0]    lmask;
  logic [7:0]    ldp;
  logic [31:0]   lval;
  logic [CW-1:0] cnt;
  logic [2:0]    top;
  logic [3:0]    nib;
  logic          grant_b;

  function automatic logic [6:0] seg(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h7B;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h75;
      4'h4: s = 7'h36;
      4'h5: s = 7'h57;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h77;
      4'hA: s = 7'h7E;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4B;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h4E;
    endcase
    return s;
  endfunction

  // Highest pending digit bit, so digits go out leftmost first.
  always_comb begin
    top = 3'd0;
    for (int i = 0; i < 8; i++)
      if (lmask[i]) top = 3'(i);
  end

  assign nib     = lval[{top, 2'b00} +: 4];
  assign grant_b = b.req & (~a.req | ptr_b);
  assign a.ack   = a_ack;
  assign b.ack   = b_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr_b  <= 1'b0;
      issued <= 1'b0;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      lmask  <= '0;
      ldp    <= '0;
      lval   <= '0;
      cnt    <= '0;
      wr     <= 1'b0;
      mask   <= '0;
      data   <= '0;
      busy   <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      if (clken) begin
        if (cnt < HMAX) cnt <= cnt + 1'b1;
        unique case (state)
          IDLE: begin
            if (a.req || b.req) begin
              unique case (1'b1)
                grant_b: begin
                  lmask <= b.mask;
                  lval  <= b.value;
                  ldp   <= b.dp;
                  b_ack <= 1'b1;
                  ptr_b <= 1'b0;
                end
                default: begin
                  lmask <= a.mask;
                  lval  <= a.value;
                  ldp   <= a.dp;
                  a_ack <= 1'b1;
                  ptr_b <= 1'b1;
                end
              endcase
              issued <= 1'b0;
              busy   <= 1'b1;
              state  <= SCAN;
            end
          end
          SCAN: begin
            if (lmask != 8'h00) begin
              mask  <= 8'h01 << top;
              data  <= {~ldp[top], seg(nib)};
              state <= WR_HI;
            end else if (issued) begin
              mask  <= '0;
              data  <= '0;
              state <= HOLD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          WR_HI: begin
            wr <= 1'b1;
            // Holdoff is timed from the first strobe of the request.
            if (!issued) begin
              cnt    <= '0;
              issued <= 1'b1;
            end
            state <= WR_LO;
          end
          WR_LO: begin
            wr         <= 1'b0;
            lmask[top] <= 1'b0;
            state      <= SCAN;
          end
          HOLD: begin
            if (cnt >= HMAX) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tm1638_sched.sv
// tb_tm1638_sched: directed vector table plus hand-written
// sequences for arbitration, mid-op reset and clken stall.
module tb_tm1638_sched;
  localparam int HOLDOFF = 440;
  localparam int LIM = 6000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clken = 1'b0;
  logic       wr;
  logic       busy;
  logic [7:0] mask;
  logic [7:0] data;

  tm1638_req_if ia ();
  tm1638_req_if ib ();

  tm1638_sched #(.HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .a     (ia),
    .b     (ib),
    .wr    (wr),
    .mask  (mask),
    .data  (data),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic       clken_en = 1'b1;
  logic [1:0] div = 2'd0;
  always @(negedge clk) begin
    div   = div + 2'd1;
    clken = clken_en && (div == 2'd0);
  end

  int tick = 0;
  always @(posedge clk)
    if (clken) tick <= tick + 1;

  int         rise_q[$];
  int         fall_q[$];
  logic [7:0] mq[$];
  logic [7:0] dq[$];
  int         busy_fall = 0;
  int         ack_tick = 0;
  int         a_cnt = 0;
  int         b_cnt = 0;
  logic       wr_q = 1'b0;
  logic       busy_q = 1'b0;

  always @(posedge clk) begin
    #2;
    if (wr && !wr_q) begin
      rise_q.push_back(tick);
      mq.push_back(mask);
      dq.push_back(data);
    end
    if (!wr && wr_q) fall_q.push_back(tick);
    if (busy_q && !busy) busy_fall = tick;
    if (ia.ack) begin a_cnt++; ack_tick = tick; end
    if (ib.ack) begin b_cnt++; ack_tick = tick; end
    wr_q   = wr;
    busy_q = busy;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d..%0d",
               nm, act, act, lo, hi);
    end
  endtask

  typedef struct {
    logic        is_b;
    logic [7:0]  m;
    logic [31:0] v;
    logic [7:0]  dp;
    int          n;
    logic [63:0] em;
    logic [63:0] ed;
  } vec_t;

  vec_t vt[7];

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    mq.delete();
    dq.delete();
    a_cnt = 0;
    b_cnt = 0;
  endtask

  task automatic wait_ack(input string nm);
    int n;
    for (n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (ia.ack || ib.ack) break;
    end
    if (n == LIM) chk({nm, "_ack_timeout"}, 1, 0, 0);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    for (n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == LIM) chk({nm, "_busy_timeout"}, 1, 0, 0);
  endtask

  task automatic start_req(input int k);
    int t0;
    clear_mon();
    @(negedge clk);
    t0 = tick;
    if (vt[k].is_b) begin
      ib.mask = vt[k].m; ib.value = vt[k].v;
      ib.dp = vt[k].dp; ib.req = 1'b1;
    end else begin
      ia.mask = vt[k].m; ia.value = vt[k].v;
      ia.dp = vt[k].dp; ia.req = 1'b1;
    end
    wait_ack($sformatf("v%0d", k));
    ia.req = 1'b0;
    ib.req = 1'b0;
    chk($sformatf("v%0d_ack_latency", k), ack_tick - t0, 0, 2);
  endtask

  task automatic finish_req(input int k);
    string p;
    p = $sformatf("v%0d", k);
    wait_idle(p);
    chk({p, "_a_ack_cnt"}, a_cnt, !vt[k].is_b, !vt[k].is_b);
    chk({p, "_b_ack_cnt"}, b_cnt, vt[k].is_b, vt[k].is_b);
    chk({p, "_n_wr"}, rise_q.size(), vt[k].n, vt[k].n);
    chk({p, "_n_fall"}, fall_q.size(), vt[k].n, vt[k].n);
    if (rise_q.size() == vt[k].n && fall_q.size() == vt[k].n) begin
      for (int i = 0; i < vt[k].n; i++) begin
        chk($sformatf("%s_mask%0d", p, i), mq[i],
            vt[k].em[63-8*i -: 8], vt[k].em[63-8*i -: 8]);
        chk($sformatf("%s_data%0d", p, i), dq[i],
            vt[k].ed[63-8*i -: 8], vt[k].ed[63-8*i -: 8]);
        chk($sformatf("%s_width%0d", p, i),
            fall_q[i] - rise_q[i], 1, 1);
        if (i > 0)
          chk($sformatf("%s_space%0d", p, i),
              rise_q[i] - rise_q[i-1], 3, 3);
      end
    end
    if (vt[k].n > 0 && rise_q.size() > 0)
      chk({p, "_holdoff"}, busy_fall - rise_q[0],
          HOLDOFF, HOLDOFF + 2);
    else
      chk({p, "_idle_ret"}, busy_fall - ack_tick, 0, 2);
  endtask

  task automatic run_vec(input int k);
    start_req(k);
    finish_req(k);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    vt[0] = '{1'b0, 8'hFF, 32'h0123ABCD, 8'h00, 8,
              64'h80402010_08040201, 64'hFBB0EDF5_FE9FCBBD};
    vt[1] = '{1'b0, 8'h01, 32'h0000000F, 8'h01, 1,
              64'h01000000_00000000, 64'h4E000000_00000000};
    vt[2] = '{1'b1, 8'h00, 32'h00000000, 8'h00, 0,
              64'h0, 64'h0};
    vt[3] = '{1'b0, 8'hA5, 32'h89ABCDEF, 8'hA0, 4,
              64'h80200401_00000000, 64'h7F7EBDCE_00000000};
    vt[4] = '{1'b1, 8'h3C, 32'h01234567, 8'h0C, 4,
              64'h20100804_00000000, 64'hEDF53657_00000000};
    vt[5] = '{1'b1, 8'h42, 32'h06000090, 8'h00, 2,
              64'h40020000_00000000, 64'hDFF70000_00000000};
    vt[6] = '{1'b0, 8'hC0, 32'h12000000, 8'h00, 2,
              64'h80400000_00000000, 64'hB0ED0000_00000000};

    ia.req = 1'b0; ia.mask = '0; ia.value = '0; ia.dp = '0;
    ib.req = 1'b0; ib.mask = '0; ib.value = '0; ib.dp = '0;
    repeat (6) @(negedge clk);
    chk("rst_wr", wr, 0, 0);
    chk("rst_mask", mask, 0, 0);
    chk("rst_data", data, 0, 0);
    chk("rst_busy", busy, 0, 0);
    chk("rst_a_ack", ia.ack, 0, 0);
    chk("rst_b_ack", ib.ack, 0, 0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(k);

    // Reset while digit 3 is being strobed.
    start_req(0);
    for (n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (wr && mask == 8'h10) break;
    end
    chk("midrst_reach", n, 0, LIM - 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wr", wr, 0, 0);
    chk("midrst_mask", mask, 0, 0);
    chk("midrst_data", data, 0, 0);
    chk("midrst_busy", busy, 0, 0);
    reset = 1'b0;
    run_vec(0);

    // clken stalled while wr is high.
    start_req(6);
    for (n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (wr) break;
    end
    clken_en = 1'b0;
    repeat (50) @(negedge clk);
    chk("stall_wr", wr, 1, 1);
    chk("stall_mask", mask, 8'h80, 8'h80);
    clken_en = 1'b1;
    finish_req(6);

    // Round robin: A first, then B over a re-asserted A.
    reset_dut();
    clear_mon();
    @(negedge clk);
    ia.mask = 8'h80; ia.value = 32'h10000000; ia.dp = 8'h00;
    ib.mask = 8'h80; ib.value = 32'h20000000; ib.dp = 8'h00;
    ia.req = 1'b1;
    ib.req = 1'b1;
    wait_ack("rr1");
    chk("rr1_a_ack", ia.ack, 1, 1);
    chk("rr1_b_ack", ib.ack, 0, 0);
    ia.req = 1'b0;
    for (n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (rise_q.size() > 0) break;
    end
    r0 = (rise_q.size() > 0) ? rise_q[0] : 0;
    chk("rr1_data", (mq.size() > 0) ? dq[0] : 0, 8'hB0, 8'hB0);
    ia.value = 32'h30000000;
    ia.req = 1'b1;
    wait_ack("rr2");
    chk("rr2_b_ack", ib.ack, 1, 1);
    chk("rr2_a_ack", ia.ack, 0, 0);
    chk("rr2_holdoff", ack_tick - r0, HOLDOFF, 1 << 30);
    ib.req = 1'b0;
    wait_ack("rr3");
    chk("rr3_a_ack", ia.ack, 1, 1);
    ia.req = 1'b0;
    wait_idle("rr");
    chk("rr_n_wr", rise_q.size(), 3, 3);
    if (dq.size() == 3) begin
      chk("rr2_data", dq[1], 8'hED, 8'hED);
      chk("rr3_data", dq[2], 8'hF5, 8'hF5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
